// File: rtl/conv_col_feeder.sv
// Column feeder for the KxK sliding-window register: buffers K_H-1 rows of a
// raster pixel stream and emits one K_H-tall column per accepted pixel.
module conv_col_feeder #(
  parameter int unsigned K_H   = 3,
  parameter int unsigned K_W   = 3,
  parameter int unsigned IMG_W = 8,
  parameter int unsigned IMG_H = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         pix_valid,
  input  logic [7:0]                   pix_data,
  output logic                         pix_ready,
  output logic [K_H-1:0][7:0]          col_data,
  output logic                         load_en,
  output logic                         clear,
  output logic                         win_valid,
  output logic [$clog2(IMG_H)-1:0]     out_row,
  output logic [$clog2(IMG_W)-1:0]     out_col,
  output logic                         frame_done,
  output logic                         busy
);

  localparam int unsigned RW = $clog2(IMG_H);
  localparam int unsigned CW = $clog2(IMG_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLR,
    S_STREAM,
    S_DONE
  } state_t;

  state_t          state;
  state_t          state_d;
  logic [RW-1:0]   r;
  logic [RW-1:0]   r_d;
  logic [CW-1:0]   c;
  logic [CW-1:0]   c_d;
  logic            accept;
  logic            last_col;
  logic            last_row;
  logic            ld_win;
  logic [RW-1:0]   ld_r;
  logic [CW-1:0]   ld_c;
  logic [K_H-1:0][7:0] col_nxt;
  logic [7:0]      rd [K_H-1];

  assign accept   = pix_valid && pix_ready;
  assign last_col = (c == CW'(IMG_W - 1));
  assign last_row = (r == RW'(IMG_H - 1));

  // CLR and DONE each take two cycles: the first overlaps the load of the
  // previous column, the second carries the clear / frame_done pulse, so a
  // clear never lands on a load cycle.
  always_comb begin
    state_d = state;
    r_d     = r;
    c_d     = c;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLR;
          r_d     = '0;
          c_d     = '0;
        end
      end
      S_CLR: begin
        if (clear) state_d = S_STREAM;
      end
      S_STREAM: begin
        if (accept) begin
          if (!last_col) begin
            c_d = c + CW'(1);
          end else if (!last_row) begin
            c_d     = '0;
            r_d     = r + RW'(1);
            state_d = S_CLR;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (frame_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and control outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      r          <= '0;
      c          <= '0;
      pix_ready  <= 1'b0;
      busy       <= 1'b0;
      clear      <= 1'b0;
      frame_done <= 1'b0;
      load_en    <= 1'b0;
      ld_win     <= 1'b0;
      ld_r       <= '0;
      ld_c       <= '0;
      win_valid  <= 1'b0;
      out_row    <= '0;
      out_col    <= '0;
    end else begin
      state      <= state_d;
      r          <= r_d;
      c          <= c_d;
      pix_ready  <= (state_d == S_STREAM);
      busy       <= (state_d != S_IDLE);
      clear      <= (state == S_CLR) && !clear;
      frame_done <= (state == S_DONE) && !frame_done;
      load_en    <= accept;
      if (accept) begin
        ld_r   <= r;
        ld_c   <= c;
        ld_win <= (32'(r) >= K_H - 1) && (32'(c) >= K_W - 1);
      end
      win_valid <= load_en && ld_win;
      if (load_en) begin
        out_row <= ld_r;
        out_col <= ld_c;
      end
    end
  end

  assign col_nxt[K_H-1] = pix_data;

  // One line buffer per stored row; row K_H-2 is the most recent row.
  for (genvar g = 0; g < K_H - 1; g++) begin : g_row
    localparam int unsigned ABOVE = K_H - 1 - g;
    logic [IMG_W-1:0][7:0] mem;
    logic [7:0]            shift_in;

    if (g == K_H - 2) begin : g_top
      assign shift_in = pix_data;
    end else begin : g_mid
      assign shift_in = rd[g+1];
    end

    assign rd[g] = mem[c];
    // Rows above the image read as zero, hiding stale data from earlier frames.
    assign col_nxt[g] = (32'(r) < ABOVE) ? 8'h00 : mem[c];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem <= '0;
      end else if (accept) begin
        mem[c] <= shift_in;
      end
    end
  end

  // Column register holds its value between loads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_data <= '0;
    end else if (accept) begin
      col_data <= col_nxt;
    end
  end

endmodule
